// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive-Euclid GCD engine: controller state
// encoding and the default datapath width.
package gcd_pkg;

    // Controller states; encodings are fixed so that debug traces are stable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_e;

    // Default operand / result / iteration-counter width.
    localparam int GCD_WIDTH_DEFAULT = 8;

endpackage : gcd_pkg

// File: rtl/gcd_ctrl.sv
// Controller for the GCD engine. Owns the IDLE/CALC/DONE state machine and
// turns the datapath comparator flags into register load enables.
// a_eq_b / a_gt_b compare the working operand registers; a_zero / b_zero
// describe the operands currently presented on the input port.
module gcd_ctrl
    import gcd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic out_ready,
    input  logic a_eq_b,
    input  logic a_gt_b,
    input  logic a_zero,
    input  logic b_zero,
    output logic in_ready,
    output logic out_valid,
    output logic ld_ops,       // load working registers from the input port
    output logic ld_res_in,    // zero-operand shortcut: result taken from the input port
    output logic ld_res_calc,  // iteration converged: result taken from regA
    output logic sub_a,        // regA <= regA - regB
    output logic sub_b,        // regB <= regB - regA
    output logic cnt_inc       // one subtraction performed this cycle
);

    gcd_state_e state_q;
    logic       out_valid_q;
    logic       accept;

    // Operands can only be taken in IDLE, and never while reset is asserted.
    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign accept    = in_valid & in_ready;

    // Decode the per-cycle datapath actions from the current state and flags.
    always_comb begin
        ld_ops      = 1'b0;
        ld_res_in   = 1'b0;
        ld_res_calc = 1'b0;
        sub_a       = 1'b0;
        sub_b       = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (a_zero | b_zero) begin
                        ld_res_in = 1'b1;
                    end else begin
                        ld_ops = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (a_eq_b) begin
                    ld_res_calc = 1'b1;
                end else if (a_gt_b) begin
                    sub_a   = 1'b1;
                    cnt_inc = 1'b1;
                end else begin
                    sub_b   = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State register with registered out_valid, set on every entry into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (a_zero | b_zero) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (a_eq_b) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule : gcd_ctrl

// File: rtl/gcd_unit.sv
// Subtractive-Euclid GCD engine, one subtraction per clock. Holds the
// working operand registers, comparator, single subtractor, result and
// saturating iteration counter; sequencing lives in gcd_ctrl.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic             err,
    output logic [WIDTH-1:0] iter_count
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] iter_q, iter_d;

    logic             a_eq_b, a_gt_b, a_zero, b_zero;
    logic [WIDTH-1:0] sub_lhs, sub_rhs, diff;
    logic             ld_ops, ld_res_in, ld_res_calc, sub_a, sub_b, cnt_inc;

    assign a_eq_b = (reg_a_q == reg_b_q);
    assign a_gt_b = (reg_a_q >  reg_b_q);
    assign a_zero = (a_in == '0);
    assign b_zero = (b_in == '0);

    // One subtractor; the operand swap keeps it larger-minus-smaller.
    assign sub_lhs = a_gt_b ? reg_a_q : reg_b_q;
    assign sub_rhs = a_gt_b ? reg_b_q : reg_a_q;
    assign diff    = sub_lhs - sub_rhs;

    gcd_ctrl u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .a_eq_b      (a_eq_b),
        .a_gt_b      (a_gt_b),
        .a_zero      (a_zero),
        .b_zero      (b_zero),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .ld_ops      (ld_ops),
        .ld_res_in   (ld_res_in),
        .ld_res_calc (ld_res_calc),
        .sub_a       (sub_a),
        .sub_b       (sub_b),
        .cnt_inc     (cnt_inc)
    );

    // Next-state for operands, result, error flag and saturating counter.
    always_comb begin
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        iter_d  = iter_q;

        if (ld_ops) begin
            reg_a_d = a_in;
            reg_b_d = b_in;
        end else if (sub_a) begin
            reg_a_d = diff;
        end else if (sub_b) begin
            reg_b_d = diff;
        end

        // With a zero operand the result is simply the other one (0 if both).
        if (ld_res_in) begin
            gcd_d = a_zero ? b_in : a_in;
        end else if (ld_res_calc) begin
            gcd_d = reg_a_q;
        end

        if (ld_ops | ld_res_in) begin
            err_d  = a_zero & b_zero;
            iter_d = '0;
        end else if (cnt_inc && (iter_q != CNT_MAX)) begin
            iter_d = iter_q + 1'b1;
        end
    end

    // Datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a_q <= '0;
            reg_b_q <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
            iter_q  <= '0;
        end else begin
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
            iter_q  <= iter_d;
        end
    end

    assign gcd_out    = gcd_q;
    assign err        = err_q;
    assign iter_count = iter_q;

endmodule : gcd_unit
